// File: rtl/alu_op_sequencer.sv
// Self-test driver for the two-stroke ALU controller: plays a latched vector
// onto the switch bus and CLKb pushbutton, then checks the registered result.
//
// state   | meaning
// IDLE    | waiting for a vector, CLKb high, bus holds last values
// SETUP_A | bus = A/op, CLKb high (GAP)
// LOW_A   | first stroke, CLKb low (PULSE)
// HOLD_A  | CLKb high, bus still A/op (GAP)
// SETUP_B | bus = B, CLKb high (GAP)
// LOW_B   | second stroke, CLKb low (PULSE)
// SETTLE  | CLKb high, result settling (GAP)
// CHECK   | compare C register and flags with expectation (1 cycle)
module alu_op_sequencer #(
  parameter int N            = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic         CLK50M,
  input  logic         reset,
  input  logic         vec_valid,
  output logic         vec_ready,
  input  logic [N-1:0] vec_a,
  input  logic [N-1:0] vec_b,
  input  logic [1:0]   vec_op,
  input  logic [N-1:0] vec_res,
  input  logic [3:0]   vec_flags,
  output logic [N-1:0] INPUT,
  output logic [1:0]   ALUcontrol,
  output logic         CLKb,
  input  logic [N-1:0] dut_res,
  input  logic [3:0]   dut_flags,
  output logic         res_valid,
  output logic         res_pass,
  output logic [7:0]   pass_cnt,
  output logic [7:0]   fail_cnt,
  output logic         busy
);

  localparam int MAXD = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP_A, LOW_A, HOLD_A, SETUP_B, LOW_B, SETTLE, CHECK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [3:0]    flags_q;
  logic          match;
  logic          tc;

  assign vec_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign match     = (dut_res == res_q) && (dut_flags == flags_q);
  assign tc        = (cnt == '0);

  always_ff @(posedge CLK50M) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      INPUT      <= '0;
      ALUcontrol <= 2'b00;
      CLKb       <= 1'b1;
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      pass_cnt   <= 8'd0;
      fail_cnt   <= 8'd0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          CLKb <= 1'b1;
          if (vec_valid) begin
            INPUT      <= vec_a;
            ALUcontrol <= vec_op;
            b_q        <= vec_b;
            res_q      <= vec_res;
            flags_q    <= vec_flags;
            cnt        <= GAP_LD;
            state      <= SETUP_A;
          end
        end
        SETUP_A: begin
          if (tc) begin
            CLKb  <= 1'b0;
            cnt   <= PULSE_LD;
            state <= LOW_A;
          end else cnt <= cnt - 1'b1;
        end
        LOW_A: begin
          if (tc) begin
            CLKb  <= 1'b1;
            cnt   <= GAP_LD;
            state <= HOLD_A;
          end else cnt <= cnt - 1'b1;
        end
        HOLD_A: begin
          if (tc) begin
            INPUT <= b_q;
            cnt   <= GAP_LD;
            state <= SETUP_B;
          end else cnt <= cnt - 1'b1;
        end
        SETUP_B: begin
          if (tc) begin
            CLKb  <= 1'b0;
            cnt   <= PULSE_LD;
            state <= LOW_B;
          end else cnt <= cnt - 1'b1;
        end
        LOW_B: begin
          if (tc) begin
            CLKb  <= 1'b1;
            cnt   <= GAP_LD;
            state <= SETTLE;
          end else cnt <= cnt - 1'b1;
        end
        SETTLE: begin
          if (tc) begin
            cnt   <= '0;
            state <= CHECK;
          end else cnt <= cnt - 1'b1;
        end
        CHECK: begin
          res_valid <= 1'b1;
          res_pass  <= match;
          // saturating counters: a full counter freezes without touching the other
          if (match) begin
            if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
          end else begin
            if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
          end
          state <= IDLE;
        end
        default: begin
          CLKb  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural two-stroke ALU
// controller attached to its bus, stroke and result ports.
module tb_alu_op_sequencer;

  localparam int N   = 8;
  localparam int P   = 2;
  localparam int G   = 3;
  localparam int LAT = 4 * G + 2 * P + 2;

  logic         CLK50M = 1'b0;
  logic         reset = 1'b1;
  logic         vec_valid = 1'b0;
  logic         vec_ready;
  logic [N-1:0] vec_a = '0, vec_b = '0, vec_res = '0;
  logic [1:0]   vec_op = 2'b00;
  logic [3:0]   vec_flags = 4'h0;
  logic [N-1:0] INPUT;
  logic [1:0]   ALUcontrol;
  logic         CLKb;
  logic [N-1:0] dut_res = '0;
  logic [3:0]   dut_flags = 4'h0;
  logic         res_valid, res_pass, busy;
  logic [7:0]   pass_cnt, fail_cnt;

  alu_op_sequencer #(.N(N), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .CLK50M(CLK50M), .reset(reset), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_op(vec_op), .vec_res(vec_res),
    .vec_flags(vec_flags), .INPUT(INPUT), .ALUcontrol(ALUcontrol), .CLKb(CLKb),
    .dut_res(dut_res), .dut_flags(dut_flags), .res_valid(res_valid),
    .res_pass(res_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
  );

  always #5 CLK50M = ~CLK50M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK50M) cyc <= cyc + 1;

  // Reference ALU: {V,C,Neg,Z} and result from plain arithmetic
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    int s;
    logic [7:0] r;
    logic v, c;
    v = 1'b0; c = 1'b0;
    case (op)
      2'b00: begin
        s = int'(a) + int'(b);
        r = s[7:0]; c = (s > 255);
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      2'b01: begin
        s = int'(a) - int'(b);
        r = s[7:0]; c = (s < 0);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {v, c, r[7], (r == 8'h00), r};
  endfunction

  // Two-stroke ALU controller model: stroke 1 captures A/op, stroke 2 computes
  logic       phase = 1'b0;
  logic [7:0] a_reg = '0;
  logic [1:0] op_reg = '0;
  always @(posedge CLKb) begin
    if (reset) phase <= 1'b0;
    else if (!phase) begin
      a_reg  <= INPUT;
      op_reg <= ALUcontrol;
      phase  <= 1'b1;
    end else begin
      {dut_flags, dut_res} <= alu_ref(a_reg, INPUT, op_reg);
      phase <= 1'b0;
    end
  end

  typedef struct {
    bit       pass;
    int       pcnt;
    int       fcnt;
    int       acc;
  } sb_t;
  sb_t sb[$];
  int exp_p = 0;
  int exp_f = 0;

  // Monitor: pops an expectation whenever res_valid is presented
  int low_len = 0;
  always @(negedge CLK50M) begin
    sb_t e;
    if (reset) low_len = 0;
    else begin
      checks++;
      if (vec_ready !== ~busy) begin
        errors++;
        $display("FAIL ready_vs_busy cyc=%0d ready=%b busy=%b", cyc, vec_ready, busy);
      end
      if (CLKb === 1'b0) low_len++;
      else if (low_len != 0) begin
        checks++;
        if (low_len != P) begin
          errors++;
          $display("FAIL clkb_low_width cyc=%0d actual=%0d expected=%0d", cyc, low_len, P);
        end
        low_len = 0;
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_res_valid cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if (res_pass !== e.pass || int'(pass_cnt) != e.pcnt || int'(fail_cnt) != e.fcnt
              || (cyc - e.acc) != LAT) begin
            errors++;
            $display("FAIL result cyc=%0d actual pass=%b pcnt=%0d fcnt=%0d lat=%0d expected pass=%b pcnt=%0d fcnt=%0d lat=%0d",
                     cyc, res_pass, pass_cnt, fail_cnt, cyc - e.acc, e.pass, e.pcnt, e.fcnt, LAT);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK50M);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                      input logic [7:0] r, input logic [3:0] f, input bit keep,
                      output int acc);
    int  n;
    bit  done;
    sb_t e;
    logic [11:0] ref_v;
    n = 0; done = 0; acc = -1;
    vec_a = a; vec_b = b; vec_op = op; vec_res = r; vec_flags = f;
    vec_valid = 1'b1;
    while (!done) begin
      if (vec_ready) begin
        ref_v = alu_ref(a, b, op);
        e.pass = (ref_v[7:0] == r) && (ref_v[11:8] == f);
        if (e.pass) exp_p = (exp_p == 255) ? 255 : exp_p + 1;
        else        exp_f = (exp_f == 255) ? 255 : exp_f + 1;
        e.pcnt = exp_p; e.fcnt = exp_f; e.acc = cyc;
        sb.push_back(e);
        acc = cyc;
        done = 1;
      end
      tick();
      n++;
      if (!done && n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout cyc=%0d", cyc);
        done = 1;
      end
    end
    if (!keep) vec_valid = 1'b0;
  endtask

  task automatic send_good(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                           input bit keep, output int acc);
    logic [11:0] ref_v;
    ref_v = alu_ref(a, b, op);
    send(a, b, op, ref_v[7:0], ref_v[11:8], keep, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d", cyc, sb.size());
    end
    tick();
  endtask

  initial begin
    int acc0, acc1, acc2, tmp;
    logic [11:0] rv;
    logic [7:0] ra, rb;
    logic [1:0] rop;

    reset = 1'b1;
    tick(); tick();
    chk("rst_vec_ready", vec_ready, 0);
    chk("rst_input", INPUT, 0);
    chk("rst_aluctl", ALUcontrol, 0);
    chk("rst_clkb", CLKb, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_pass", res_pass, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", vec_ready, 1);

    send(8'h05, 8'h03, 2'b00, 8'h08, 4'b0000, 0, tmp);
    drain();
    chk("add_dut_res", dut_res, 8'h08);
    chk("add_pass_cnt", pass_cnt, 1);
    chk("add_res_pass", res_pass, 1);
    chk("idle_clkb", CLKb, 1);
    chk("idle_input_held", INPUT, 8'h03);

    send(8'h05, 8'h03, 2'b00, 8'h09, 4'b0000, 0, tmp);
    drain();
    chk("mis_res_fail_cnt", fail_cnt, 1);
    chk("mis_res_pass_cnt", pass_cnt, 1);
    send(8'h05, 8'h03, 2'b00, 8'h08, 4'b0001, 0, tmp);
    drain();
    chk("mis_flags_fail_cnt", fail_cnt, 2);

    send_good(8'h10, 8'h01, 2'b01, 1, acc0);
    send_good(8'hF0, 8'h3C, 2'b10, 1, acc1);
    send_good(8'h0F, 8'h30, 2'b11, 0, acc2);
    chk("b2b_spacing_1", acc1 - acc0, LAT);
    chk("b2b_spacing_2", acc2 - acc1, LAT);
    drain();
    chk("b2b_or_res", dut_res, 8'h3F);

    send_good(8'h7F, 8'h01, 2'b00, 0, tmp);
    for (int i = 0; i < 14; i++) begin
      vec_valid = 1'($urandom);
      vec_a = 8'($urandom);
      vec_b = 8'($urandom);
      vec_op = 2'($urandom);
      tick();
    end
    vec_valid = 1'b0;
    drain();
    chk("held_off_res", dut_res, 8'h80);
    chk("held_off_flags", dut_flags, 4'b1010);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom);
      rv = alu_ref(ra, rb, rop);
      case ($urandom_range(0, 3))
        0: rv[7:0] = rv[7:0] ^ 8'($urandom_range(1, 255));
        1: rv[11:8] = rv[11:8] ^ 4'($urandom_range(1, 15));
        default: ;
      endcase
      send(ra, rb, rop, rv[7:0], rv[11:8], ($urandom_range(0, 1) == 1), tmp);
    end
    vec_valid = 1'b0;
    drain();

    send_good(8'h22, 8'h11, 2'b00, 0, tmp);
    for (int i = 0; i < 3 * G + P; i++) tick();
    chk("in_low_b_clkb", CLKb, 0);
    reset = 1'b1;
    tick();
    sb.delete();
    exp_p = 0; exp_f = 0;
    chk("midrst_clkb", CLKb, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_pass_cnt", pass_cnt, 0);
    chk("midrst_fail_cnt", fail_cnt, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_ready", vec_ready, 0);
    reset = 1'b0;
    tick();
    send_good(8'h22, 8'h11, 2'b00, 0, tmp);
    drain();
    chk("post_midrst_pass_cnt", pass_cnt, 1);

    for (int i = 0; i < 300; i++)
      send_good(8'($urandom), 8'($urandom), 2'($urandom), 1, tmp);
    vec_valid = 1'b0;
    drain();
    chk("sat_pass_cnt", pass_cnt, 255);
    chk("sat_fail_cnt", fail_cnt, 0);
    send(8'h01, 8'h01, 2'b00, 8'h03, 4'b0000, 0, tmp);
    drain();
    chk("sat_fail_inc", fail_cnt, 1);
    chk("sat_pass_held", pass_cnt, 255);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
